// File: rtl/filt_oup_quant_pkg.sv
// Shared constants and helpers for the filter output quantiser and its FIFO.
package filt_oup_quant_pkg;

    // Default widths shared with the upstream serial-MAC FIR.
    localparam int LP_FILT_INP_WIDTH = 37;
    localparam int LP_SYS_OUP_WIDTH  = 16;

    // Ceiling log2 for sizing pointers and counters.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Largest positive two's complement value of a w-bit word.
    function automatic logic [63:0] sat_max_f(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's complement value of a w-bit word (low w bits).
    function automatic logic [63:0] sat_min_f(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/filt_sfifo.sv
// Generic synchronous show-ahead FIFO with full/empty/level.
module filt_sfifo
    import filt_oup_quant_pkg::*;
#(
    parameter int gp_data_width = 16,
    parameter int gp_depth      = 4
)(
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_wr,
    input  logic [gp_data_width-1:0]      i_wdata,
    input  logic                          i_rd,
    output logic [gp_data_width-1:0]      o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [clog2_f(gp_depth):0]    o_level
);
    localparam int AW = clog2_f(gp_depth);

    logic [gp_data_width-1:0] mem_q [gp_depth];
    logic [AW:0]              wptr_d, wptr_q;
    logic [AW:0]              rptr_d, rptr_q;
    logic                     rd_ok_s;
    logic                     wr_ok_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty = (wptr_q == rptr_q);
    assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign o_level = wptr_q - rptr_q;
    assign o_rdata = o_empty ? {gp_data_width{1'b0}} : mem_q[rptr_q[AW-1:0]];

    // Accept a write when there is room, or when a read frees the slot in the same cycle.
    always_comb begin
        rd_ok_s = i_rd && !o_empty;
        wr_ok_s = i_wr && (!o_full || rd_ok_s);
        if (wr_ok_s) begin
            wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_ok_s) begin
            rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer registers; reset empties the FIFO at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q <= {(AW+1){1'b0}};
            rptr_q <= {(AW+1){1'b0}};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (wr_ok_s) begin
            mem_q[wptr_q[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/filt_oup_quant.sv
// Output conditioning after the FIR: shift/round, saturate, decimate, buffer.
module filt_oup_quant
    import filt_oup_quant_pkg::*;
#(
    parameter int gp_inp_width  = LP_FILT_INP_WIDTH,
    parameter int gp_oup_width  = LP_SYS_OUP_WIDTH,
    parameter int gp_frac_shift = 12,
    parameter int gp_rnd_mode   = 1,
    parameter int gp_dec_factor = 1,
    parameter int gp_fifo_depth = 4
)(
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_ena,
    input  logic [gp_inp_width-1:0]           i_data,
    input  logic                              i_valid,
    output logic [gp_oup_width-1:0]           o_data,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [clog2_f(gp_fifo_depth):0]   o_level,
    output logic                              o_drop,
    output logic                              o_ovf,
    input  logic                              i_ovf_clr
);
    // One guard bit so the rounding add can never wrap.
    localparam int XW  = gp_inp_width + 1;
    localparam int CW  = (gp_dec_factor > 1) ? clog2_f(gp_dec_factor) : 1;
    localparam int RSH = (gp_frac_shift > 0) ? gp_frac_shift - 1 : 0;
    localparam logic signed [XW-1:0] RND =
        (gp_rnd_mode == 1 && gp_frac_shift > 0) ? (XW'(1) << RSH) : XW'(0);
    localparam logic [gp_oup_width-1:0] SAT_MAX  = gp_oup_width'(sat_max_f(gp_oup_width));
    localparam logic [gp_oup_width-1:0] SAT_MIN  = gp_oup_width'(sat_min_f(gp_oup_width));
    localparam logic [CW-1:0]           CNT_LAST = CW'(gp_dec_factor - 1);

    logic signed [XW-1:0]        ext_s, sum_s, r1_d, r1_q;
    logic                        v1_d, v1_q;
    logic [XW-gp_oup_width:0]    hi_s;
    logic [gp_oup_width-1:0]     r2_d, r2_q;
    logic                        v2_d, v2_q;
    logic                        clip_s;
    logic                        ovf_d, ovf_q;
    logic [CW-1:0]               cnt_d, cnt_q;
    logic                        keep_s;
    logic                        rd_s;
    logic                        full_s, empty_s;
    logic                        drop_d, drop_q;

    // Stage 1: sign-extend, add rounding constant, arithmetic shift.
    always_comb begin
        ext_s = {i_data[gp_inp_width-1], i_data};
        sum_s = ext_s + RND;
        if (i_ena) begin
            r1_d = sum_s >>> gp_frac_shift;
            v1_d = i_valid;
        end else begin
            r1_d = r1_q;
            v1_d = v1_q;
        end
    end

    // Stage 2: clip to the output width; bits above the output sign must all match the sign.
    always_comb begin
        hi_s   = r1_q[XW-1:gp_oup_width-1];
        clip_s = 1'b0;
        if (i_ena) begin
            v2_d = v1_q;
            if (!r1_q[XW-1] && (|hi_s)) begin
                r2_d   = SAT_MAX;
                clip_s = 1'b1;
            end else if (r1_q[XW-1] && !(&hi_s)) begin
                r2_d   = SAT_MIN;
                clip_s = 1'b1;
            end else begin
                r2_d = r1_q[gp_oup_width-1:0];
            end
        end else begin
            v2_d = v2_q;
            r2_d = r2_q;
        end
        // A new clip beats a simultaneous clear.
        if (clip_s && v1_q) begin
            ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Decimation counter and FIFO write/drop decision.
    always_comb begin
        keep_s = i_ena && v2_q && (cnt_q == {CW{1'b0}});
        if (i_ena && v2_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
        rd_s   = o_valid && i_ready;
        drop_d = keep_s && full_s && !rd_s;
    end

    // Pipeline, flag and counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r1_q   <= {XW{1'b0}};
            v1_q   <= 1'b0;
            r2_q   <= {gp_oup_width{1'b0}};
            v2_q   <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= {CW{1'b0}};
            drop_q <= 1'b0;
        end else begin
            r1_q   <= r1_d;
            v1_q   <= v1_d;
            r2_q   <= r2_d;
            v2_q   <= v2_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    assign o_ovf   = ovf_q;
    assign o_drop  = drop_q;
    assign o_valid = !empty_s;

    filt_sfifo #(
        .gp_data_width (gp_oup_width),
        .gp_depth      (gp_fifo_depth)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (keep_s),
        .i_wdata (r2_q),
        .i_rd    (rd_s),
        .o_rdata (o_data),
        .o_full  (full_s),
        .o_empty (empty_s),
        .o_level (o_level)
    );

endmodule
